// File: rtl/cd_csr_host.sv
// Stream-to-CSR bridge for one CDBUS slave port: polls INT_FLAG, drains RX frames
// onto a byte stream and copies TX stream frames into the TX page.
module cd_csr_host #(
  parameter logic [4:0] REG_INT_FLAG = 5'h10,
  parameter logic [4:0] REG_INT_MASK = 5'h11,
  parameter logic [4:0] REG_RX       = 5'h14,
  parameter logic [4:0] REG_TX       = 5'h15,
  parameter logic [4:0] REG_RX_CTRL  = 5'h16,
  parameter logic [4:0] REG_TX_CTRL  = 5'h17,
  parameter logic [7:0] INT_MASK_VAL = 8'h0a,
  parameter int         BIT_RX_PEND  = 1,
  parameter int         BIT_TX_FREE  = 5,
  parameter logic [7:0] RX_CLR_VAL   = 8'h02,
  parameter logic [7:0] TX_START_VAL = 8'h02,
  parameter logic [7:0] TX_DROP_VAL  = 8'h04,
  parameter int         POLL_DIV     = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       irq,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_last,
  input  logic       rx_ready,
  output logic       tx_ovf,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_POLL, ST_POLL_WAIT,
    ST_RX_STB, ST_RX_SMP, ST_RX_HOLD, ST_RX_CLR,
    ST_TX_WR, ST_TX_END
  } state_t;

  localparam logic [15:0] POLL_RELOAD = 16'(POLL_DIV);
  localparam logic [7:0]  RX_LEN_MAX  = 8'd253;

  state_t      state_q, state_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [8:0]  rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_len_q, rx_len_d;
  logic [8:0]  tx_cnt_q, tx_cnt_d;
  logic        tx_drop_q, tx_drop_d;
  logic        csr_read_q, csr_read_d;
  logic        csr_write_q, csr_write_d;
  logic [4:0]  csr_address_q, csr_address_d;
  logic [7:0]  csr_writedata_q, csr_writedata_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_last_q, rx_last_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        busy_q, busy_d;

  logic       poll_hit;
  logic       flag_rx;
  logic       flag_tx;
  logic       tx_accept;
  logic [7:0] rx_len_clamp;

  // A TX byte is only taken when the previous byte's write has already left the bus.
  assign tx_ready     = (state_q == ST_TX_WR) && !csr_write_q;
  assign tx_accept    = tx_ready && tx_valid;
  assign poll_hit     = irq || (poll_cnt_q == 16'd0);
  assign flag_rx      = csr_readdata[BIT_RX_PEND];
  assign flag_tx      = csr_readdata[BIT_TX_FREE] && tx_valid;
  assign rx_len_clamp = (csr_readdata > RX_LEN_MAX) ? RX_LEN_MAX : csr_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:      state_d = ST_IDLE;
      ST_IDLE:      if (poll_hit) state_d = ST_POLL;
      ST_POLL:      state_d = ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        if (flag_rx)      state_d = ST_RX_STB;
        else if (flag_tx) state_d = ST_TX_WR;
        else              state_d = ST_IDLE;
      end
      ST_RX_STB:    state_d = ST_RX_SMP;
      ST_RX_SMP:    state_d = ST_RX_HOLD;
      ST_RX_HOLD:   if (rx_ready) state_d = rx_last_q ? ST_RX_CLR : ST_RX_STB;
      ST_RX_CLR:    state_d = ST_IDLE;
      ST_TX_WR:     if (tx_accept && tx_last) state_d = ST_TX_END;
      ST_TX_END:    state_d = ST_IDLE;
      default:      state_d = ST_INIT;
    endcase
  end

  always_comb begin
    poll_cnt_d      = poll_cnt_q;
    rx_cnt_d        = rx_cnt_q;
    rx_len_d        = rx_len_q;
    tx_cnt_d        = tx_cnt_q;
    tx_drop_d       = tx_drop_q;
    csr_read_d      = 1'b0;
    csr_write_d     = 1'b0;
    csr_address_d   = csr_address_q;
    csr_writedata_d = csr_writedata_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_valid_q;
    rx_last_d       = rx_last_q;
    tx_ovf_d        = 1'b0;
    busy_d          = (state_d != ST_IDLE);
    case (state_q)
      ST_INIT: begin
        csr_write_d     = 1'b1;
        csr_address_d   = REG_INT_MASK;
        csr_writedata_d = INT_MASK_VAL;
        poll_cnt_d      = POLL_RELOAD;
      end
      ST_IDLE: begin
        if (poll_hit) begin
          csr_read_d    = 1'b1;
          csr_address_d = REG_INT_FLAG;
          poll_cnt_d    = POLL_RELOAD;
        end else begin
          poll_cnt_d = poll_cnt_q - 16'd1;
        end
      end
      ST_POLL_WAIT: begin
        if (flag_rx) begin
          csr_read_d    = 1'b1;
          csr_address_d = REG_RX;
          rx_cnt_d      = 9'd0;
          rx_len_d      = 8'd0;
        end else if (flag_tx) begin
          tx_cnt_d  = 9'd0;
          tx_drop_d = 1'b0;
        end
      end
      ST_RX_SMP: begin
        // Byte 2 carries the payload length; the last byte index is 2+L.
        rx_data_d  = csr_readdata;
        rx_valid_d = 1'b1;
        if (rx_cnt_q == 9'd2) begin
          rx_len_d  = rx_len_clamp;
          rx_last_d = (rx_len_clamp == 8'd0);
        end else if (rx_cnt_q > 9'd2) begin
          rx_last_d = (rx_cnt_q == ({1'b0, rx_len_q} + 9'd2));
        end else begin
          rx_last_d = 1'b0;
        end
      end
      ST_RX_HOLD: begin
        if (rx_ready) begin
          rx_valid_d = 1'b0;
          rx_last_d  = 1'b0;
          rx_cnt_d   = rx_cnt_q + 9'd1;
          if (!rx_last_q) begin
            csr_read_d    = 1'b1;
            csr_address_d = REG_RX;
          end
        end
      end
      ST_RX_CLR: begin
        csr_write_d     = 1'b1;
        csr_address_d   = REG_RX_CTRL;
        csr_writedata_d = RX_CLR_VAL;
      end
      ST_TX_WR: begin
        if (tx_accept) begin
          // Only the first 256 bytes fit in the page; the rest are swallowed.
          if (!tx_cnt_q[8]) begin
            csr_write_d     = 1'b1;
            csr_address_d   = REG_TX;
            csr_writedata_d = tx_data;
          end
          tx_cnt_d = (tx_cnt_q == 9'h1ff) ? tx_cnt_q : tx_cnt_q + 9'd1;
          if (tx_last) tx_drop_d = tx_cnt_q[8];
        end
      end
      ST_TX_END: begin
        csr_write_d     = 1'b1;
        csr_address_d   = REG_TX_CTRL;
        csr_writedata_d = tx_drop_q ? TX_DROP_VAL : TX_START_VAL;
        tx_ovf_d        = tx_drop_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt_q      <= 16'd0;
      rx_cnt_q        <= 9'd0;
      rx_len_q        <= 8'd0;
      tx_cnt_q        <= 9'd0;
      tx_drop_q       <= 1'b0;
      csr_read_q      <= 1'b0;
      csr_write_q     <= 1'b0;
      csr_address_q   <= 5'd0;
      csr_writedata_q <= 8'd0;
      rx_data_q       <= 8'd0;
      rx_valid_q      <= 1'b0;
      rx_last_q       <= 1'b0;
      tx_ovf_q        <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      poll_cnt_q      <= poll_cnt_d;
      rx_cnt_q        <= rx_cnt_d;
      rx_len_q        <= rx_len_d;
      tx_cnt_q        <= tx_cnt_d;
      tx_drop_q       <= tx_drop_d;
      csr_read_q      <= csr_read_d;
      csr_write_q     <= csr_write_d;
      csr_address_q   <= csr_address_d;
      csr_writedata_q <= csr_writedata_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_last_q       <= rx_last_d;
      tx_ovf_q        <= tx_ovf_d;
      busy_q          <= busy_d;
    end
  end

  assign csr_read      = csr_read_q;
  assign csr_write     = csr_write_q;
  assign csr_address   = csr_address_q;
  assign csr_writedata = csr_writedata_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_last       = rx_last_q;
  assign tx_ovf        = tx_ovf_q;
  assign busy          = busy_q;

endmodule
